// File: rtl/sweep_ctrl_if.sv
// sweep_ctrl_if: sweep request, link control and per-point result bundle.
// The master side drives the request and sim_done; the slave is the controller.
interface sweep_ctrl_if #(
  parameter int RX_W  = 4,
  parameter int TX_W  = 4,
  parameter int CNT_W = 32
);
  logic             start;
  logic [RX_W-1:0]  rx_max;
  logic [TX_W-1:0]  tx_max;
  logic [CNT_W-1:0] timeout;
  logic             sim_done;
  logic             rst_dut;
  logic [RX_W-1:0]  rx_setting;
  logic [TX_W-1:0]  tx_setting;
  logic             busy;
  logic             point_valid;
  logic [CNT_W-1:0] point_cycles;
  logic             point_timeout;
  logic             sweep_done;

  modport master (
    output start, rx_max, tx_max, timeout, sim_done,
    input  rst_dut, rx_setting, tx_setting, busy,
    input  point_valid, point_cycles, point_timeout,
    input  sweep_done
  );

  modport slave (
    input  start, rx_max, tx_max, timeout, sim_done,
    output rst_dut, rx_setting, tx_setting, busy,
    output point_valid, point_cycles, point_timeout,
    output sweep_done
  );
endinterface

// File: rtl/sweep_ctrl.sv
// sweep_ctrl: walks rx (inner) x tx (outer) settings, resetting and timing the link.
// Optional per-point watchdog: define SWEEP_CTRL_TIMEOUT_EN.
module sweep_ctrl #(
  parameter int RX_W       = 4,
  parameter int TX_W       = 4,
  parameter int RST_CYCLES = 16,
  parameter int CNT_W      = 32
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  sweep_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    RECORD,
    DONE
  } state_t;

  localparam int RC_W =
    (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0] RC_LAST =
    RC_W'(RST_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [RX_W-1:0]  rx_lim;
  logic [RX_W-1:0]  rx_set;
  logic [TX_W-1:0]  tx_lim;
  logic [TX_W-1:0]  tx_set;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic [RC_W-1:0]  rc;
  logic             hit_to;
  logic             more;
  logic             rst_dut_q;
  logic             busy_q;
  logic             pv_q;
  logic             pt_q;
  logic             sd_q;

  assign cnt_inc = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign more    = (rx_set < rx_lim) || (tx_set < tx_lim);

`ifdef SWEEP_CTRL_TIMEOUT_EN
  logic [CNT_W-1:0] to_lim;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      to_lim <= '0;
    end else if (state == IDLE && bus.start) begin
      to_lim <= bus.timeout;
    end
  end

  // A zero limit disables the watchdog.
  assign hit_to = (to_lim != '0) && (cnt_inc == to_lim);
`else
  logic unused_timeout;

  assign unused_timeout = ^bus.timeout;
  assign hit_to         = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (bus.start) state_nxt = RESET;
      RESET:  if (rc == RC_LAST) state_nxt = RUN;
      RUN: begin
        if (bus.sim_done || hit_to) state_nxt = RECORD;
      end
      RECORD: state_nxt = more ? RESET : DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rx_lim <= '0;
      tx_lim <= '0;
      rx_set <= '0;
      tx_set <= '0;
      cnt    <= '0;
      rc     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            rx_lim <= bus.rx_max;
            tx_lim <= bus.tx_max;
            rx_set <= '0;
            tx_set <= '0;
            rc     <= '0;
          end
        end
        RESET: begin
          rc  <= rc + RC_W'(1);
          cnt <= '0;
        end
        RUN: cnt <= cnt_inc;
        RECORD: begin
          rc <= '0;
          // Settings move only here, so they hold while the link runs.
          if (rx_set < rx_lim) begin
            rx_set <= rx_set + RX_W'(1);
          end else if (tx_set < tx_lim) begin
            rx_set <= '0;
            tx_set <= tx_set + TX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rst_dut_q <= 1'b1;
      busy_q    <= 1'b0;
      pv_q      <= 1'b0;
      pt_q      <= 1'b0;
      sd_q      <= 1'b0;
    end else begin
      rst_dut_q <= (state_nxt == IDLE) ||
                   (state_nxt == RESET) ||
                   (state_nxt == DONE);
      busy_q    <= state_nxt != IDLE;
      pv_q      <= state_nxt == RECORD;
      pt_q      <= (state == RUN) &&
                   !bus.sim_done && hit_to;
      sd_q      <= state_nxt == DONE;
    end
  end

  assign bus.rst_dut       = rst_dut_q;
  assign bus.busy          = busy_q;
  assign bus.point_valid   = pv_q;
  assign bus.point_timeout = pt_q;
  assign bus.sweep_done    = sd_q;
  assign bus.point_cycles  = cnt;
  assign bus.rx_setting    = rx_set;
  assign bus.tx_setting    = tx_set;

endmodule

// File: doc/sweep_ctrl.md
SWEEP_CTRL -- requirements
Module: sweep_ctrl

Interface
REQ-001 Parameter RX_W, default 4: width of rx_setting.
REQ-002 Parameter TX_W, default 4: width of tx_setting.
REQ-003 Parameter RST_CYCLES, default 16: clk_sys cycles rst_dut is held high per point (at least 1).
REQ-004 Parameter CNT_W, default 32: width of the per-point cycle counter and timeout limit.
REQ-005 clk_sys  in  1  system clock; the only clock.
REQ-006 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 start  in  1  single-cycle request to begin a sweep; ignored unless in IDLE.
REQ-008 rx_max  in  RX_W  last rx_setting of the sweep (inclusive), sampled at start.
REQ-009 tx_max  in  TX_W  last tx_setting of the sweep (inclusive), sampled at start.
REQ-010 timeout  in  CNT_W  per-point cycle limit, sampled at start.
REQ-011 sim_done  in  1  level from the emulated link, set when emulated time reaches its stop time.
REQ-012 rst_dut  out  1  active-high reset to the emulated link.
REQ-013 rx_setting  out  RX_W  current RX (CTLE) setting.
REQ-014 tx_setting  out  TX_W  current TX FFE setting.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 point_valid  out  1  one-cycle pulse when a point completes.
REQ-017 point_cycles  out  CNT_W  clk_sys cycles spent in RUN for the completed point; valid while point_valid is high.
REQ-018 point_timeout  out  1  qualifies point_valid: that point ended on timeout.
REQ-019 sweep_done  out  1  one-cycle pulse after the final point.

Function
REQ-020 States: IDLE, RESET, RUN, RECORD, DONE.
REQ-021 IDLE with start=1: latch rx_max, tx_max and timeout; set rx_setting=0 and tx_setting=0; go to RESET.
REQ-022 RESET: rst_dut=1 for exactly RST_CYCLES cycles, then go to RUN with rst_dut=0.
REQ-023 RUN: the cycle counter starts at 0 on entry and increments by 1 each cycle; it saturates at all-ones and does not wrap.
REQ-024 RUN: sim_done=1 sampled on a rising clock edge causes a transition to RECORD on that edge.
REQ-025 RECORD lasts 1 cycle: point_valid=1; point_cycles holds the counter value; point_timeout reports the exit cause.
REQ-026 Sweep order: rx_setting is the inner loop, tx_setting the outer loop.
REQ-027 After RECORD, if rx_setting<rx_max: rx_setting+1, then RESET.
REQ-028 Else if tx_setting<tx_max: rx_setting=0 and tx_setting+1, then RESET.
REQ-029 Else go to DONE.
REQ-030 DONE lasts 1 cycle: sweep_done=1; then IDLE. rx_setting and tx_setting keep their final values.
REQ-031 Setting outputs change only on the RECORD-to-RESET transition, so they are stable whenever rst_dut=0.
REQ-032 sim_done seen in RESET is ignored; a stale sim_done from the prior point is cleared by rst_dut.
REQ-033 rx_max=0 and tx_max=0 give exactly one point.
REQ-034 start while busy=1 has no effect.
REQ-035 Total points = (rx_max+1)*(tx_max+1); no setting counter exceeds its latched maximum or wraps.

Reset
REQ-036 On rst_n low, asynchronously: state=IDLE, rst_dut=1, both settings=0, busy=0, point_valid=0, point_timeout=0, sweep_done=0, point_cycles=0.
REQ-037 In IDLE after reset, rst_dut stays 1 so the link is held until a sweep starts.
REQ-038 rst_n asserted mid-sweep aborts the sweep with no point_valid or sweep_done pulse.

Configuration
REQ-039 Macro SWEEP_CTRL_TIMEOUT_EN defined: in RUN, counter reaching the latched timeout with sim_done=0 goes to RECORD with point_timeout=1; timeout=0 disables the watchdog.
REQ-040 SWEEP_CTRL_TIMEOUT_EN undefined: no watchdog logic exists, the timeout input is unused, point_timeout is tied 0, and RUN exits only on sim_done.
REQ-041 If sim_done and the timeout limit occur on the same edge, sim_done wins (point_timeout=0).

Verification
REQ-042 rx_max=1, tx_max=1, sim_done asserted 50 cycles into each RUN -> 4 point_valid pulses with (tx,rx)=(0,0),(0,1),(1,0),(1,1), each point_cycles=50, then one sweep_done.
REQ-043 rx_max=0, tx_max=0 -> one point, then sweep_done; rst_dut asserted for 16 cycles before RUN.
REQ-044 TIMEOUT_EN on, timeout=100, sim_done never asserted -> point_valid with point_timeout=1 and point_cycles=100.
REQ-045 TIMEOUT_EN on, sim_done and timeout limit on the same edge -> point_timeout=0.
REQ-046 rst_n pulsed low during the second RUN -> immediate IDLE with rst_dut=1 and settings=0, no pulses; a start pulse during busy is ignored.
